mac_operand_loader: RTL and testbench

Sequential front-end that fills the 64-lane dot-product MAC's operand inputs. On `start` it reads 64 Q8.8 data words, then 64 Q8.8 weight words, one word per cycle from a single-port operand SRAM. It assembles them into two flat parallel buses and presents them to the MAC with a valid/ready handshake. It sits between the operand SRAM and the MAC's data1..64 / weight1..64 inputs.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_operand_loader_if.sv | 25 ++
 rtl/mac_operand_loader_bank.sv | 26 ++
 rtl/mac_operand_loader.sv | 107 ++++++++++
 tb/tb_mac_operand_loader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the 64-lane Q8.8 dot-product MAC and its loaders.
// Holds the operand geometry and the operand-loader state encoding.
package mac_pkg;

    localparam int DW     = 16;
    localparam int FRAC   = 8;
    localparam int N_ELEM = 64;
    localparam int AW     = 12;
    localparam int LW     = $clog2(N_ELEM);
    localparam int IW     = $clog2(2 * N_ELEM);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    typedef logic [N_ELEM*DW-1:0] vec_t;

endpackage

// File: rtl/mac_operand_loader_if.sv
// Operand SRAM read port plus the operand-vector handshake toward the MAC.
// The loader is the master; SRAM and MAC sit on the slave side.
interface mac_operand_loader_if
    import mac_pkg::*;
    ;

    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          vec_valid;
    logic          vec_ready;
    vec_t          data_flat;
    vec_t          weight_flat;

    modport master (
        output mem_rd_en, mem_addr, vec_valid, data_flat, weight_flat,
        input  mem_rd_data, vec_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, vec_valid, data_flat, weight_flat,
        output mem_rd_data, vec_ready
    );

endinterface

// File: rtl/mac_operand_loader_bank.sv
// N_ELEM x DW operand register file: one synchronous write port,
// asynchronous clear, and the whole contents exposed as a flat bus.
module mac_operand_bank
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [LW-1:0] idx_i,
    input  logic [DW-1:0] wdata_i,
    output vec_t          flat_o
);

    vec_t flat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flat_q <= '0;
        end else if (we_i) begin
            flat_q[idx_i*DW +: DW] <= wdata_i;
        end
    end

    assign flat_o = flat_q;

endmodule

// File: rtl/mac_operand_loader.sv
// Streams 64 data then 64 weight words out of the operand SRAM and
// presents them to the MAC as two flat buses under valid/ready.
module mac_operand_loader
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] data_base,
    input  logic [AW-1:0] weight_base,
    output logic          busy,
    output logic          done,
    mac_operand_loader_if.master bus
);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] dbase_q, wbase_q;
    logic          cap_valid_q;
    logic [IW-1:0] cap_idx_q;
    logic          done_q, done_d;
    logic          rd_en;
    logic [AW-1:0] base_sel;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(2*N_ELEM-1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.vec_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dbase_q     <= '0;
            wbase_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_valid_q <= rd_en;
            cap_idx_q   <= idx_q;
            done_q      <= done_d;
            if (state_q == ST_IDLE && start) begin
                dbase_q <= data_base;
                wbase_q <= weight_base;
            end
        end
    end

    // Upper half of the issue index walks the weight region; wraps mod 2^AW.
    assign rd_en    = (state_q == ST_FETCH);
    assign base_sel = idx_q[IW-1] ? wbase_q : dbase_q;

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_en ? base_sel + AW'(idx_q[LW-1:0]) : '0;
    assign bus.vec_valid = (state_q == ST_PRESENT);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

    mac_operand_bank u_data_bank (
        .clk     (clk),
        .reset   (reset),
        .we_i    (cap_valid_q && !cap_idx_q[IW-1]),
        .idx_i   (cap_idx_q[LW-1:0]),
        .wdata_i (bus.mem_rd_data),
        .flat_o  (bus.data_flat)
    );

    mac_operand_bank u_weight_bank (
        .clk     (clk),
        .reset   (reset),
        .we_i    (cap_valid_q && cap_idx_q[IW-1]),
        .idx_i   (cap_idx_q[LW-1:0]),
        .wdata_i (bus.mem_rd_data),
        .flat_o  (bus.weight_flat)
    );

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: SRAM model, address log and a lane-level
// reference of what each load must present to the MAC.
module tb_mac_operand_loader;
    import mac_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] data_base;
    logic [AW-1:0] weight_base;
    logic          busy;
    logic          done;

    mac_operand_loader_if bus ();

    mac_operand_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_base   (data_base),
        .weight_base (weight_base),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1<<AW];
    logic [AW-1:0] addr_log [$];

    initial bus.mem_rd_data = '0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (!reset && bus.mem_rd_en) addr_log.push_back(bus.mem_addr);
    end

    int vectors = 0;
    int errs    = 0;

    task automatic run_load(input logic [AW-1:0] db, input logic [AW-1:0] wb,
                            input int hold, input bit poke);
        vec_t          exp_d;
        vec_t          exp_w;
        logic [AW-1:0] exp_a [2*N_ELEM];
        logic [AW-1:0] a;
        int            lat;
        bit            ok;
        for (int i = 0; i < N_ELEM; i++) begin
            a = db + AW'(i);
            exp_a[i] = a;
            exp_d[i*DW +: DW] = mem[a];
            a = wb + AW'(i);
            exp_a[N_ELEM+i] = a;
            exp_w[i*DW +: DW] = mem[a];
        end
        addr_log.delete();
        @(negedge clk);
        start = 1'b1;
        data_base = db;
        weight_base = wb;
        bus.vec_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        data_base = AW'($urandom);
        weight_base = AW'($urandom);
        lat = 0;
        while (!bus.vec_valid && lat < 400) begin
            start = poke && (lat == 10);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (lat !== 129) begin
            errs++;
            $display("FAIL latency: got %0d cycles, expected 129", lat);
        end
        if (lat >= 400) begin
            bus.vec_ready = 1'b0;
            return;
        end
        vectors++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL done_with_valid: done=%b, expected 0", done);
        end
        vectors++;
        if (bus.data_flat !== exp_d) begin
            errs++;
            $display("FAIL data_flat: got %h expected %h", bus.data_flat[127:0], exp_d[127:0]);
        end
        vectors++;
        if (bus.weight_flat !== exp_w) begin
            errs++;
            $display("FAIL weight_flat: got %h expected %h", bus.weight_flat[127:0], exp_w[127:0]);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.vec_valid !== 1'b1 || done !== 1'b0 ||
                bus.data_flat !== exp_d || bus.weight_flat !== exp_w) begin
                errs++;
                $display("FAIL hold[%0d]: valid=%b done=%b, expected valid=1 done=0 stable buses",
                         k, bus.vec_valid, done);
            end
        end
        bus.vec_ready = 1'b1;
        start = poke;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || bus.vec_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL handshake: done=%b valid=%b busy=%b, expected 1 0 0",
                     done, bus.vec_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL post_done: done=%b busy=%b, expected 0 0", done, busy);
        end
        ok = (addr_log.size() == 2*N_ELEM);
        for (int i = 0; i < 2*N_ELEM && ok; i++) begin
            if (addr_log[i] !== exp_a[i]) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            errs++;
            $display("FAIL addr_seq: got %0d reads first %h, expected 128 reads first %h",
                     addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : '0, exp_a[0]);
        end
        bus.vec_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== '0 || bus.vec_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 ||
            bus.data_flat !== '0 || bus.weight_flat !== '0) begin
            errs++;
            $display("FAIL %s: rd_en=%b addr=%h valid=%b busy=%b done=%b banks_nonzero=%b, expected all 0",
                     name, bus.mem_rd_en, bus.mem_addr, bus.vec_valid, busy, done,
                     (bus.data_flat != '0) || (bus.weight_flat != '0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        data_base = '0;
        weight_base = '0;
        bus.vec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        run_load(12'h000, 12'h100, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_load(12'hFF0, 12'h400, 0, 1'b0);
        vectors++;
        if (bus.data_flat[16*DW +: DW] !== mem[0]) begin
            errs++;
            $display("FAIL wrap_lane16: got %h expected %h", bus.data_flat[16*DW +: DW], mem[0]);
        end
    endtask

    task automatic test_backpressure();
        run_load(12'h020, 12'h180, 20, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_load(12'h040, 12'h200, 0, 1'b1);
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL no_restart: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        data_base = 12'h300;
        weight_base = 12'h500;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset_mid");
        @(negedge clk);
        reset = 1'b0;
        run_load(12'h0A0, 12'h7F0, 3, 1'b0);
    endtask

    task automatic test_mac();
        longint   acc;
        logic [DW-1:0] res;
        for (int i = 0; i < N_ELEM; i++) begin
            mem[12'h600 + i] = 16'h0100;
            mem[12'h700 + i] = 16'h0080;
        end
        run_load(12'h600, 12'h700, 0, 1'b0);
        acc = 0;
        for (int i = 0; i < N_ELEM; i++) begin
            acc += longint'($signed(bus.data_flat[i*DW +: DW])) *
                   longint'($signed(bus.weight_flat[i*DW +: DW]));
        end
        res = DW'(acc >>> FRAC);
        vectors++;
        if (res !== 16'h2000) begin
            errs++;
            $display("FAIL mac_result: got %h expected 2000", res);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
            run_load(AW'($urandom), AW'($urandom), int'($urandom_range(0, 5)), 1'b0);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a + 1);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_mac();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
